// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for a 16-way shared resource: offers a one-hot/encoded grant,
// holds it through valid/ready acceptance and a busy phase, with a busy-phase watchdog.
module rr_encoder_arbiter #(
  parameter int N_REQ   = 16,
  parameter int IDX_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [N_REQ-1:0] req_i,
  output logic             grant_valid_o,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  input  logic             grant_ready_i,
  input  logic             done_i,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_e;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] last_ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;
  logic             busy_q;
  logic             timeout_q;
  logic [7:0]       wd_q;

  logic [IDX_W-1:0] pick_idx_d;
  logic             pick_vld_d;
  logic [IDX_W-1:0] cand;

  // Search upward from the requester after the last accepted one; the index
  // arithmetic wraps naturally because N_REQ is a power of two.
  always_comb begin
    pick_idx_d = '0;
    pick_vld_d = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last_ptr_q + IDX_W'(i);
      if (!pick_vld_d && req_i[cand]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ptr_q <= '1;
      idx_q      <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= 8'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && pick_vld_d) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            grant_q <= N_REQ'(1) << pick_idx_d;
            idx_q   <= pick_idx_d;
          end
        end
        OFFER: begin
          if (grant_ready_i) begin
            state_q    <= BUSY;
            busy_q     <= 1'b1;
            last_ptr_q <= idx_q;
            wd_q       <= 8'd0;
          end
        end
        BUSY: begin
          // A completion arriving on the watchdog's final cycle suppresses the timeout pulse.
          if (done_i || wd_q == WD_LIMIT) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= '0;
            idx_q     <= '0;
            wd_q      <= 8'd0;
            timeout_q <= !done_i;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid_o = valid_q;
  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench for rr_encoder_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a cycle-level reference model.
module tb_rr_encoder_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [15:0] req_i;
  logic        grant_ready_i;
  logic        done_i;
  logic        grant_valid_o;
  logic [15:0] grant_o;
  logic [3:0]  grant_idx_o;
  logic        busy_o;
  logic        timeout_o;

  int passCount  = 0;
  int checkCount = 0;

  bit modelOn = 1'b0;
  int mPhase;
  int mIdx;
  int mPtr;
  int mCnt;
  bit mTo;

  typedef struct {
    bit          en;
    logic [15:0] req;
    bit          rdy;
    bit          done;
    bit          expValid;
    int          expIdx;
    bit          expBusy;
    bit          expTo;
  } vec_t;

  vec_t vecs[14];

  rr_encoder_arbiter #(.N_REQ(16), .IDX_W(4), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .req_i         (req_i),
    .grant_valid_o (grant_valid_o),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .grant_ready_i (grant_ready_i),
    .done_i        (done_i),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkAll(input string tag, input bit v, input int idx, input bit b, input bit t);
    logic [15:0] g;
    int          ei;
    g  = v ? (16'h1 << idx) : 16'h0;
    ei = v ? idx : 0;
    checkOutput({tag, " valid"},   32'(grant_valid_o), 32'(v));
    checkOutput({tag, " grant"},   32'(grant_o),       32'(g));
    checkOutput({tag, " idx"},     32'(grant_idx_o),   32'(ei));
    checkOutput({tag, " busy"},    32'(busy_o),        32'(b));
    checkOutput({tag, " timeout"}, 32'(timeout_o),     32'(t));
  endtask

  task automatic applyStimulus(input bit en, input logic [15:0] req, input bit rdy, input bit done);
    enable_i      = en;
    req_i         = req;
    grant_ready_i = rdy;
    done_i        = done;
  endtask

  // Reference behaviour: BUSY persists for at most TO cycles unless done arrives.
  task automatic modelStep();
    bit found;
    int j;
    mTo = 1'b0;
    case (mPhase)
      0: if (enable_i && req_i != 16'h0) begin
           found = 1'b0;
           for (int k = 1; k <= 16; k++) begin
             j = (mPtr + k) % 16;
             if (!found && req_i[j]) begin
               found = 1'b1;
               mIdx  = j;
             end
           end
           mPhase = 1;
         end
      1: if (grant_ready_i) begin
           mPtr   = mIdx;
           mPhase = 2;
           mCnt   = 0;
         end
      default: begin
        mCnt++;
        if (done_i) mPhase = 0;
        else if (mCnt == TO) begin
          mPhase = 0;
          mTo    = 1'b1;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (modelOn) modelStep();
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 0,  1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 0,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 15, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 15, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 15, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 15, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 0,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 0,  1'b1, 1'b0};
    vecs[11] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkAll("reset", 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].en, vecs[i].req, vecs[i].rdy, vecs[i].done);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expIdx, vecs[i].expBusy, vecs[i].expTo);
    end

    // Full request vector: grants walk 0..15 and wrap, one every three cycles.
    applyReset();
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b1);
    for (int k = 0; k <= 16; k++) begin
      tick();
      checkAll($sformatf("wrap%0d offer", k), 1'b1, k % 16, 1'b0, 1'b0);
      tick();
      checkAll($sformatf("wrap%0d busy", k), 1'b1, k % 16, 1'b1, 1'b0);
      tick();
      checkAll($sformatf("wrap%0d idle", k), 1'b0, 0, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0);
    tick();
    checkAll("wd offer", 1'b1, 8, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    for (int c = 0; c < TO; c++) begin
      tick();
      checkAll($sformatf("wd busy%0d", c), 1'b1, 8, 1'b1, 1'b0);
    end
    tick();
    checkAll("wd pulse", 1'b0, 0, 1'b0, 1'b1);
    tick();
    checkAll("wd pulse end", 1'b0, 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0);
    tick();
    checkAll("dw offer", 1'b1, 8, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    for (int c = 0; c < TO; c++) begin
      tick();
      checkAll($sformatf("dw busy%0d", c), 1'b1, 8, 1'b1, 1'b0);
      if (c == TO - 1) applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
    end
    tick();
    checkAll("dw done wins", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    checkAll("dw after", 1'b0, 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0);
    tick();
    checkAll("en offer", 1'b1, 4, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0);
    tick();
    checkAll("en busy0", 1'b1, 4, 1'b1, 1'b0);
    tick();
    checkAll("en busy1", 1'b1, 4, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0010, 1'b1, 1'b1);
    tick();
    checkAll("en release", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0010, 1'b1, 1'b0);
    tick();
    checkAll("en blocked0", 1'b0, 0, 1'b0, 1'b0);
    tick();
    checkAll("en blocked1", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
    tick();
    checkAll("en resume", 1'b1, 4, 1'b0, 1'b0);

    applyReset();
    applyStimulus(1'b1, 16'h0080, 1'b1, 1'b0);
    tick();
    checkAll("rst offer7", 1'b1, 7, 1'b0, 1'b0);
    tick();
    checkAll("rst busy7", 1'b1, 7, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkAll("rst async busy", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0081, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkAll("rst ptr0", 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0081, 1'b1, 1'b0);
    tick();
    checkAll("rst busy0", 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
    tick();
    checkAll("rst idle", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
    tick();
    checkAll("rst next1", 1'b1, 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkAll("rst async offer", 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkAll("rst ptr restart", 1'b1, 0, 1'b0, 1'b0);

    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    applyReset();
    mPhase  = 0;
    mIdx    = 0;
    mPtr    = 15;
    mCnt    = 0;
    mTo     = 1'b0;
    modelOn = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'h0;
      applyStimulus($urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      tick();
      checkAll($sformatf("rand%0d", n), mPhase != 0, mIdx, mPhase == 2, mTo);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
